// File: rtl/ssd1306_pkg.sv
// Shared SSD1306 definitions: panel geometry, opcodes, addressing modes and parser state.
package ssd1306_pkg;

  localparam int unsigned COLS   = 128;
  localparam int unsigned PAGES  = 8;
  localparam int unsigned COL_W  = 7;
  localparam int unsigned PAGE_W = 3;
  localparam int unsigned ADDR_W = PAGE_W + COL_W;

  localparam logic [7:0] CMD_SET_COL_LO   = 8'h00;
  localparam logic [7:0] CMD_SET_COL_HI   = 8'h10;
  localparam logic [7:0] CMD_MEM_MODE     = 8'h20;
  localparam logic [7:0] CMD_COL_ADDR     = 8'h21;
  localparam logic [7:0] CMD_PAGE_ADDR    = 8'h22;
  localparam logic [7:0] CMD_START_LINE   = 8'h40;
  localparam logic [7:0] CMD_CONTRAST     = 8'h81;
  localparam logic [7:0] CMD_CHARGE_PUMP  = 8'h8D;
  localparam logic [7:0] CMD_NORMAL       = 8'hA6;
  localparam logic [7:0] CMD_INVERT       = 8'hA7;
  localparam logic [7:0] CMD_MUX_RATIO    = 8'hA8;
  localparam logic [7:0] CMD_DISPLAY_OFF  = 8'hAE;
  localparam logic [7:0] CMD_DISPLAY_ON   = 8'hAF;
  localparam logic [7:0] CMD_PAGE_START   = 8'hB0;
  localparam logic [7:0] CMD_DISP_OFFSET  = 8'hD3;
  localparam logic [7:0] CMD_CLK_DIV      = 8'hD5;
  localparam logic [7:0] CMD_PRECHARGE    = 8'hD9;
  localparam logic [7:0] CMD_COM_PINS     = 8'hDA;
  localparam logic [7:0] CMD_VCOMH        = 8'hDB;

  localparam logic [1:0] MODE_HORIZ = 2'd0;
  localparam logic [1:0] MODE_VERT  = 2'd1;
  localparam logic [1:0] MODE_PAGE  = 2'd2;

  typedef enum logic [1:0] {ST_OP, ST_ARG1, ST_ARG2} parse_state_e;

  // Opcodes that take exactly one argument byte.
  function automatic logic is_one_arg(input logic [7:0] op);
    return op inside {CMD_CONTRAST, CMD_MEM_MODE, CMD_MUX_RATIO, CMD_DISP_OFFSET,
                      CMD_CLK_DIV, CMD_PRECHARGE, CMD_COM_PINS, CMD_VCOMH, CMD_CHARGE_PUMP};
  endfunction

  // Pointer advance: wrap to start on reaching end, otherwise increment modulo the field width.
  function automatic logic [COL_W-1:0] col_step(input logic [COL_W-1:0] p,
                                                input logic [COL_W-1:0] s,
                                                input logic [COL_W-1:0] e);
    return (p == e) ? s : p + COL_W'(1);
  endfunction

  function automatic logic [PAGE_W-1:0] page_step(input logic [PAGE_W-1:0] p,
                                                  input logic [PAGE_W-1:0] s,
                                                  input logic [PAGE_W-1:0] e);
    return (p == e) ? s : p + PAGE_W'(1);
  endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// Pin synchronisers, SCLK rising-edge detect and 8-bit MSB-first deserialiser.
module spi_byte_rx #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       io_sclk,
  input  logic       io_sdin,
  input  logic       io_cs,
  input  logic       io_dc,
  output logic [7:0] rx_byte,
  output logic       byte_dc,
  output logic       byte_done
);

  logic [SYNC_STAGES-1:0] sclk_sync_q, sdin_sync_q, cs_sync_q, dc_sync_q;
  logic       sclk_s, sdin_s, cs_s, dc_s, sclk_prev_q, rise;
  logic [6:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] byte_q, byte_d;
  logic       dc_q, dc_d, done_q, done_d;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign sdin_s = sdin_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign dc_s   = dc_sync_q[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_prev_q;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    dc_d    = dc_q;
    done_d  = 1'b0;
    if (cs_s) begin
      cnt_d   = 3'd0;
      shift_d = 7'd0;
    end else if (rise) begin
      shift_d = {shift_q[5:0], sdin_s};
      cnt_d   = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        byte_d = {shift_q, sdin_s};
        dc_d   = dc_s;
        done_d = 1'b1;
      end
    end
  end

  // SCLK and CS synchronisers reset to their idle-high level so release of reset is not seen as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '1;
      cs_sync_q   <= '1;
      sdin_sync_q <= '0;
      dc_sync_q   <= '0;
      sclk_prev_q <= 1'b1;
      shift_q     <= 7'd0;
      cnt_q       <= 3'd0;
      byte_q      <= 8'd0;
      dc_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      sclk_sync_q <= (sclk_sync_q << 1) | SYNC_STAGES'(io_sclk);
      sdin_sync_q <= (sdin_sync_q << 1) | SYNC_STAGES'(io_sdin);
      cs_sync_q   <= (cs_sync_q << 1) | SYNC_STAGES'(io_cs);
      dc_sync_q   <= (dc_sync_q << 1) | SYNC_STAGES'(io_dc);
      sclk_prev_q <= sclk_s;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      byte_q      <= byte_d;
      dc_q        <= dc_d;
      done_q      <= done_d;
    end
  end

  assign rx_byte   = byte_q;
  assign byte_dc   = dc_q;
  assign byte_done = done_q;

endmodule

// File: rtl/ssd1306_spi_rx.sv
// SSD1306 4-wire SPI receiver: command decode, display registers and framebuffer writes.
module ssd1306_spi_rx
  import ssd1306_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              io_sclk,
  input  logic              io_sdin,
  input  logic              io_cs,
  input  logic              io_dc,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_wdata,
  output logic              display_on,
  output logic              invert,
  output logic [7:0]        contrast,
  output logic [5:0]        start_line,
  output logic              cmd_strobe
);

  logic [7:0] rx_byte;
  logic       byte_dc, byte_done;

  spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_byte_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .io_sclk   (io_sclk),
    .io_sdin   (io_sdin),
    .io_cs     (io_cs),
    .io_dc     (io_dc),
    .rx_byte   (rx_byte),
    .byte_dc   (byte_dc),
    .byte_done (byte_done)
  );

  parse_state_e      state_q, state_d;
  logic [7:0]        op_q, op_d;
  logic [COL_W-1:0]  arg1_q, arg1_d;
  logic [1:0]        mode_q, mode_d;
  logic [COL_W-1:0]  col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
  logic [PAGE_W-1:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
  logic              fb_we_q, fb_we_d, cmd_strobe_q, cmd_strobe_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [7:0]        fb_wdata_q, fb_wdata_d, contrast_q, contrast_d;
  logic              display_on_q, display_on_d, invert_q, invert_d;
  logic [5:0]        start_line_q, start_line_d;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    arg1_d       = arg1_q;
    mode_d       = mode_q;
    col_d        = col_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    page_d       = page_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    fb_we_d      = 1'b0;
    cmd_strobe_d = 1'b0;
    fb_addr_d    = fb_addr_q;
    fb_wdata_d   = fb_wdata_q;
    contrast_d   = contrast_q;
    display_on_d = display_on_q;
    invert_d     = invert_q;
    start_line_d = start_line_q;
    if (byte_done && byte_dc) begin
      // A data byte also aborts any half-received multi-byte command.
      fb_we_d    = 1'b1;
      fb_addr_d  = {page_q, col_q};
      fb_wdata_d = rx_byte;
      state_d    = ST_OP;
      case (mode_q)
        MODE_HORIZ: begin
          col_d = col_step(col_q, col_start_q, col_end_q);
          if (col_q == col_end_q) page_d = page_step(page_q, page_start_q, page_end_q);
        end
        MODE_VERT: begin
          page_d = page_step(page_q, page_start_q, page_end_q);
          if (page_q == page_end_q) col_d = col_step(col_q, col_start_q, col_end_q);
        end
        default: col_d = col_step(col_q, col_start_q, col_end_q);
      endcase
    end else if (byte_done) begin
      cmd_strobe_d = 1'b1;
      case (state_q)
        ST_OP: begin
          op_d = rx_byte;
          if (rx_byte == CMD_DISPLAY_OFF)         display_on_d = 1'b0;
          else if (rx_byte == CMD_DISPLAY_ON)     display_on_d = 1'b1;
          else if (rx_byte == CMD_NORMAL)         invert_d     = 1'b0;
          else if (rx_byte == CMD_INVERT)         invert_d     = 1'b1;
          else if (rx_byte[7:6] == CMD_START_LINE[7:6]) start_line_d = rx_byte[5:0];
          else if (rx_byte[7:3] == CMD_PAGE_START[7:3]) page_d       = rx_byte[2:0];
          else if (rx_byte[7:4] == CMD_SET_COL_LO[7:4]) col_d[3:0]   = rx_byte[3:0];
          else if (rx_byte[7:3] == CMD_SET_COL_HI[7:3]) col_d[6:4]   = rx_byte[2:0];
          else if (is_one_arg(rx_byte) || rx_byte == CMD_COL_ADDR || rx_byte == CMD_PAGE_ADDR)
            state_d = ST_ARG1;
        end
        ST_ARG1: begin
          arg1_d  = rx_byte[6:0];
          state_d = ST_OP;
          if (op_q == CMD_CONTRAST) contrast_d = rx_byte;
          else if (op_q == CMD_MEM_MODE && rx_byte[1:0] != 2'd3) mode_d = rx_byte[1:0];
          else if (op_q == CMD_COL_ADDR || op_q == CMD_PAGE_ADDR) state_d = ST_ARG2;
        end
        ST_ARG2: begin
          state_d = ST_OP;
          if (op_q == CMD_COL_ADDR) begin
            col_start_d = arg1_q;
            col_end_d   = rx_byte[6:0];
            col_d       = arg1_q;
          end else begin
            page_start_d = arg1_q[2:0];
            page_end_d   = rx_byte[2:0];
            page_d       = arg1_q[2:0];
          end
        end
        default: state_d = ST_OP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_OP;
      op_q         <= 8'd0;
      arg1_q       <= '0;
      mode_q       <= MODE_PAGE;
      col_q        <= '0;
      col_start_q  <= '0;
      col_end_q    <= COL_W'(COLS - 1);
      page_q       <= '0;
      page_start_q <= '0;
      page_end_q   <= PAGE_W'(PAGES - 1);
      fb_we_q      <= 1'b0;
      cmd_strobe_q <= 1'b0;
      fb_addr_q    <= '0;
      fb_wdata_q   <= 8'd0;
      contrast_q   <= 8'h7F;
      display_on_q <= 1'b0;
      invert_q     <= 1'b0;
      start_line_q <= 6'd0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      arg1_q       <= arg1_d;
      mode_q       <= mode_d;
      col_q        <= col_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      page_q       <= page_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
      fb_we_q      <= fb_we_d;
      cmd_strobe_q <= cmd_strobe_d;
      fb_addr_q    <= fb_addr_d;
      fb_wdata_q   <= fb_wdata_d;
      contrast_q   <= contrast_d;
      display_on_q <= display_on_d;
      invert_q     <= invert_d;
      start_line_q <= start_line_d;
    end
  end

  assign fb_we      = fb_we_q;
  assign cmd_strobe = cmd_strobe_q;
  assign fb_addr    = fb_addr_q;
  assign fb_wdata   = fb_wdata_q;
  assign contrast   = contrast_q;
  assign display_on = display_on_q;
  assign invert     = invert_q;
  assign start_line = start_line_q;

endmodule

// File: tb/tb_ssd1306_spi_rx.sv
// Scoreboard bench for ssd1306_spi_rx: SPI driver, arithmetic reference model, output monitor.
module tb_ssd1306_spi_rx;

  localparam int LAT = 4;  // two sync stages + byte_done register + output register

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       io_sclk = 1'b1, io_sdin = 1'b0, io_cs = 1'b1, io_dc = 1'b0;
  logic       fb_we, display_on, invert, cmd_strobe;
  logic [9:0] fb_addr;
  logic [7:0] fb_wdata, contrast;
  logic [5:0] start_line;

  ssd1306_spi_rx #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .io_sclk(io_sclk), .io_sdin(io_sdin), .io_cs(io_cs), .io_dc(io_dc),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata), .display_on(display_on),
    .invert(invert), .contrast(contrast), .start_line(start_line), .cmd_strobe(cmd_strobe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {bit is_data; int addr; int data; int t;} exp_t;
  exp_t expq[$];
  int total = 0, bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: panel state kept as plain integers.
  int m_mode, m_col, m_page, m_cs, m_ce, m_ps, m_pe;
  int m_disp, m_inv, m_con, m_sl, m_op, m_need;
  int m_args[$];

  function automatic void m_reset();
    m_mode = 2; m_col = 0; m_page = 0; m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7;
    m_disp = 0; m_inv = 0; m_con = 127; m_sl = 0; m_op = 0; m_need = 0;
    m_args.delete();
    expq.delete();
  endfunction

  function automatic int nxt(input int p, input int s, input int e, input int w);
    return (p == e) ? s : (p + 1) % w;
  endfunction

  function automatic void m_byte(input bit dc, input int b, input int t);
    exp_t e;
    e.is_data = dc; e.t = t;
    e.addr = dc ? m_page * 128 + m_col : 0;
    e.data = dc ? b : 0;
    expq.push_back(e);
    if (dc) begin
      m_need = 0;
      m_args.delete();
      if (m_mode == 0) begin
        if (m_col == m_ce) m_page = nxt(m_page, m_ps, m_pe, 8);
        m_col = nxt(m_col, m_cs, m_ce, 128);
      end else if (m_mode == 1) begin
        if (m_page == m_pe) m_col = nxt(m_col, m_cs, m_ce, 128);
        m_page = nxt(m_page, m_ps, m_pe, 8);
      end else begin
        m_col = nxt(m_col, m_cs, m_ce, 128);
      end
    end else if (m_need > 0) begin
      m_args.push_back(b);
      if (m_args.size() == m_need) begin
        case (m_op)
          'h81: m_con = m_args[0];
          'h20: if (m_args[0] % 4 != 3) m_mode = m_args[0] % 4;
          'h21: begin m_cs = m_args[0] % 128; m_ce = m_args[1] % 128; m_col = m_cs; end
          'h22: begin m_ps = m_args[0] % 8; m_pe = m_args[1] % 8; m_page = m_ps; end
          default: ;
        endcase
        m_need = 0;
        m_args.delete();
      end
    end else begin
      m_op = b;
      if (b == 'hAE) m_disp = 0;
      else if (b == 'hAF) m_disp = 1;
      else if (b == 'hA6) m_inv = 0;
      else if (b == 'hA7) m_inv = 1;
      else if (b >= 'h40 && b <= 'h7F) m_sl = b - 'h40;
      else if (b >= 'hB0 && b <= 'hB7) m_page = b - 'hB0;
      else if (b <= 'h0F) m_col = (m_col / 16) * 16 + b;
      else if (b >= 'h10 && b <= 'h17) m_col = (b - 'h10) * 16 + m_col % 16;
      else if (b == 'h81 || b == 'h20 || b == 'hA8 || b == 'hD3 || b == 'hD5 ||
               b == 'hD9 || b == 'hDA || b == 'hDB || b == 'h8D) m_need = 1;
      else if (b == 'h21 || b == 'h22) m_need = 2;
    end
  endfunction

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input bit dc, input logic [7:0] b, input int h, input bit gap);
    if (gap && !io_cs) begin io_cs = 1'b1; step(2); end
    if (io_cs) begin io_cs = 1'b0; step(1); end
    io_dc = dc;
    for (int i = 7; i >= 0; i--) begin
      io_sclk = 1'b0; io_sdin = b[i]; step(h);
      io_sclk = 1'b1;
      if (i == 0) m_byte(dc, int'(b), cyc);
      step(h);
    end
  endtask

  task automatic send_partial(input logic [7:0] b, input int n);
    if (io_cs) begin io_cs = 1'b0; step(1); end
    io_dc = 1'b0;
    for (int i = 7; i > 7 - n; i--) begin
      io_sclk = 1'b0; io_sdin = b[i]; step(1);
      io_sclk = 1'b1; step(1);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (expq.size() != 0 && n < 300) begin step(1); n++; end
    step(4);
    chk({name, "_pending"}, expq.size(), 0);
  endtask

  task automatic check_status(input string name);
    chk({name, "_display_on"}, int'(display_on), m_disp);
    chk({name, "_invert"}, int'(invert), m_inv);
    chk({name, "_contrast"}, int'(contrast), m_con);
    chk({name, "_start_line"}, int'(start_line), m_sl);
  endtask

  task automatic check_reset(input string name);
    chk({name, "_fb_we"}, int'(fb_we), 0);
    chk({name, "_cmd_strobe"}, int'(cmd_strobe), 0);
    chk({name, "_fb_addr"}, int'(fb_addr), 0);
    chk({name, "_fb_wdata"}, int'(fb_wdata), 0);
    check_status(name);
  endtask

  // Monitor: every strobe pops one expectation and checks kind, latency and payload.
  exp_t me;
  always @(negedge clk) begin
    if (rst_n && (fb_we || cmd_strobe)) begin
      if (expq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_strobe: fb_we=%0b cmd_strobe=%0b with empty scoreboard", fb_we, cmd_strobe);
      end else begin
        me = expq.pop_front();
        chk("fb_we_kind", int'(fb_we), int'(me.is_data));
        chk("cmd_strobe_kind", int'(cmd_strobe), int'(!me.is_data));
        chk("latency", cyc - me.t, LAT);
        if (me.is_data) begin
          chk("fb_addr", int'(fb_addr), me.addr);
          chk("fb_wdata", int'(fb_wdata), me.data);
        end
      end
    end
  end

  logic [7:0] init_seq [23] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
                                8'h8D, 8'h14, 8'h20, 8'h00, 8'hDA, 8'h12, 8'h81, 8'h7F,
                                8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
  logic [7:0] win_seq [6]  = '{8'h21, 8'h10, 8'h12, 8'h22, 8'h02, 8'h03};
  logic [7:0] vert_seq [8] = '{8'h20, 8'h01, 8'h21, 8'h00, 8'h01, 8'h22, 8'h06, 8'h07};
  logic [7:0] cmd_pick [14] = '{8'hAE, 8'hAF, 8'hA6, 8'hA7, 8'h81, 8'h20, 8'h21,
                                8'h22, 8'h40, 8'hB0, 8'h00, 8'h10, 8'hA8, 8'h8D};

  initial begin
    logic [7:0] b;
    m_reset();
    step(3);
    check_reset("reset");
    rst_n = 1'b1;
    step(4);
    check_reset("post_reset");

    foreach (init_seq[i]) send_byte(1'b0, init_seq[i], 1, 1'b1);
    drain("init");
    check_status("init");

    for (int i = 0; i < 1025; i++) send_byte(1'b1, 8'(i), 1, 1'b0);
    drain("fill");

    foreach (win_seq[i]) send_byte(1'b0, win_seq[i], 1, 1'b1);
    for (int i = 0; i < 7; i++) send_byte(1'b1, 8'($urandom), 1, 1'b0);
    drain("window");

    foreach (vert_seq[i]) send_byte(1'b0, vert_seq[i], 1, 1'b1);
    for (int i = 0; i < 5; i++) send_byte(1'b1, 8'($urandom), 1, 1'b0);
    drain("vertical");

    send_byte(1'b0, 8'hAE, 1, 1'b1);
    drain("off");
    send_partial(8'hAF, 5);
    io_cs = 1'b1; step(3);
    send_byte(1'b0, 8'hAF, 1, 1'b0);
    drain("partial");
    check_status("partial");

    send_byte(1'b0, 8'h81, 1, 1'b1);
    drain("pre_reset");
    send_partial(8'h55, 4);
    rst_n = 1'b0;
    m_reset();
    step(2);
    check_reset("mid_byte_reset");
    io_cs = 1'b1;
    rst_n = 1'b1;
    step(2);
    send_byte(1'b0, 8'h40, 1, 1'b0);
    drain("after_reset");
    check_status("after_reset");

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(9) < 4) b = 8'($urandom);
      else if ($urandom_range(3) == 0) b = 8'($urandom);
      else begin
        b = cmd_pick[$urandom_range(13)];
        if (b == 8'h40) b = b | 8'($urandom_range(63));
        else if (b == 8'hB0) b = b | 8'($urandom_range(7));
        else if (b == 8'h00) b = 8'($urandom_range(15));
        else if (b == 8'h10) b = b | 8'($urandom_range(7));
      end
      send_byte(1'($urandom_range(9) < 4), b, int'($urandom_range(1, 2)), 1'($urandom_range(1)));
    end
    drain("random");
    check_status("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
